// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle controller: FSM states, opcode classes,
// ALU operand selects, trap causes and the bundle of datapath control lines.
package multicycle_controller_pkg;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
    ST_MEMORY,
    ST_WRITEBACK,
    ST_TRAP
  } state_e;

  typedef enum logic [2:0] {
    CLS_OP,
    CLS_OP_IMM,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH,
    CLS_JAL,
    CLS_LUI,
    CLS_ILLEGAL
  } op_class_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_ILLEGAL = 2'd1,
    CAUSE_TIMEOUT = 2'd2
  } trap_cause_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  localparam logic       SRC_A_PC   = 1'b0;
  localparam logic       SRC_A_RS1  = 1'b1;
  localparam logic [1:0] SRC_B_RS2  = 2'd0;
  localparam logic [1:0] SRC_B_FOUR = 2'd1;
  localparam logic [1:0] SRC_B_IMM  = 2'd2;

  typedef struct packed {
    logic       imem_req;
    logic       dmem_read;
    logic       dmem_write;
    logic       pc_write;
    logic       ir_write;
    logic       rf_write;
    logic       alu_override;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_src;
    logic       mem_to_reg;
  } ctl_t;

  function automatic op_class_e decode_class(input logic [6:0] opc);
    case (opc)
      OPC_OP:     return CLS_OP;
      OPC_OP_IMM: return CLS_OP_IMM;
      OPC_LOAD:   return CLS_LOAD;
      OPC_STORE:  return CLS_STORE;
      OPC_BRANCH: return CLS_BRANCH;
      OPC_JAL:    return CLS_JAL;
      OPC_LUI:    return CLS_LUI;
      default:    return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// Datapath/memory-facing signal bundle of the multicycle controller.
// The controller uses the master view; the datapath and memories use slave.
interface multicycle_controller_if #(
  parameter int OPCODE_WIDTH    = 7,
  parameter int ALU_SRC_B_WIDTH = 2,
  parameter int RETIRE_WIDTH    = 32
);
  logic [OPCODE_WIDTH-1:0]    opCode;
  logic                       branchTaken;
  logic                       imemReady;
  logic                       dmemReady;
  logic                       imemReq;
  logic                       dmemRead;
  logic                       dmemWrite;
  logic                       PCWrite;
  logic                       IRWrite;
  logic                       regFileWrite;
  logic                       ALUOverride;
  logic                       ALUSrcA;
  logic [ALU_SRC_B_WIDTH-1:0] ALUSrcB;
  logic                       pcSrc;
  logic                       memToReg;
  logic                       trap;
  logic [1:0]                 trapCause;
  logic [RETIRE_WIDTH-1:0]    retired;

  modport master (
    input  opCode, branchTaken, imemReady, dmemReady,
    output imemReq, dmemRead, dmemWrite, PCWrite, IRWrite, regFileWrite,
           ALUOverride, ALUSrcA, ALUSrcB, pcSrc, memToReg, trap, trapCause,
           retired
  );

  modport slave (
    output opCode, branchTaken, imemReady, dmemReady,
    input  imemReq, dmemRead, dmemWrite, PCWrite, IRWrite, regFileWrite,
           ALUOverride, ALUSrcA, ALUSrcB, pcSrc, memToReg, trap, trapCause,
           retired
  );
endinterface

// File: rtl/multicycle_controller_wait_timer.sv
// Counts consecutive stalled cycles of a memory handshake; expired fires in
// the MAX_WAIT-th stalled cycle so the caller can trap instead of waiting on.
module wait_timer #(
  parameter int MAX_WAIT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);
  localparam int CNT_W = $clog2(MAX_WAIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = count_en && (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle control FSM: per-opcode-class fetch/decode/execute/memory/writeback
// sequencing with bounded memory waits, trap state and a retired counter.
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int OPCODE_WIDTH    = 7,
  parameter int ALU_SRC_B_WIDTH = 2,
  parameter int MAX_WAIT        = 15,
  parameter int RETIRE_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_controller_if.master bus
);

  state_e                  state_q, state_d;
  op_class_e               class_q, class_d;
  trap_cause_e             cause_q, cause_d;
  logic [RETIRE_WIDTH-1:0] retired_q, retired_d;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic                    retire;
  logic                    wait_cnt_en;
  logic                    wait_expired;
  ctl_t                    ctl, ctl_out;

  assign opcode = bus.opCode;

  // Only a stalled handshake counts; any ready or any other state clears.
  assign wait_cnt_en = ((state_q == ST_FETCH)  && !bus.imemReady) ||
                       ((state_q == ST_MEMORY) && !bus.dmemReady);

  wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!wait_cnt_en),
    .count_en (wait_cnt_en),
    .expired  (wait_expired)
  );

  always_comb begin
    state_d = state_q;
    class_d = class_q;
    cause_d = cause_q;
    retire  = 1'b0;
    case (state_q)
      ST_FETCH: begin
        if (bus.imemReady) begin
          state_d = ST_DECODE;
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_DECODE: begin
        class_d = decode_class(7'(opcode));
        if (class_d == CLS_ILLEGAL) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        case (class_q)
          CLS_LOAD, CLS_STORE: state_d = ST_MEMORY;
          CLS_BRANCH: begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
          default: state_d = ST_WRITEBACK;
        endcase
      end
      ST_MEMORY: begin
        if (bus.dmemReady) begin
          if (class_q == CLS_LOAD) begin
            state_d = ST_WRITEBACK;
          end else begin
            state_d = ST_FETCH;
            retire  = 1'b1;
          end
        end else if (wait_expired) begin
          state_d = ST_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      ST_WRITEBACK: begin
        state_d = ST_FETCH;
        retire  = 1'b1;
      end
      ST_TRAP: state_d = ST_TRAP;
      default: state_d = ST_FETCH;
    endcase
  end

  assign retired_d = retired_q + RETIRE_WIDTH'(retire);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      class_q   <= CLS_ILLEGAL;
      cause_q   <= CAUSE_NONE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      class_q   <= class_d;
      cause_q   <= cause_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    ctl = '0;
    case (state_q)
      ST_FETCH: begin
        ctl.imem_req     = 1'b1;
        ctl.alu_src_a    = SRC_A_PC;
        ctl.alu_src_b    = SRC_B_FOUR;
        ctl.alu_override = 1'b1;
        ctl.ir_write     = bus.imemReady;
        ctl.pc_write     = bus.imemReady;
      end
      ST_EXECUTE: begin
        case (class_q)
          CLS_OP: begin
            ctl.alu_src_a = SRC_A_RS1;
            ctl.alu_src_b = SRC_B_RS2;
          end
          CLS_OP_IMM, CLS_LUI: ctl.alu_src_b = SRC_B_IMM;
          CLS_LOAD, CLS_STORE: begin
            ctl.alu_src_a    = SRC_A_RS1;
            ctl.alu_src_b    = SRC_B_IMM;
            ctl.alu_override = 1'b1;
          end
          CLS_BRANCH: begin
            ctl.alu_src_b = SRC_B_RS2;
            ctl.pc_src    = bus.branchTaken;
            ctl.pc_write  = bus.branchTaken;
          end
          CLS_JAL: begin
            ctl.pc_src   = 1'b1;
            ctl.pc_write = 1'b1;
          end
          default: ;
        endcase
      end
      ST_MEMORY: begin
        ctl.dmem_read  = (class_q == CLS_LOAD);
        ctl.dmem_write = (class_q == CLS_STORE);
      end
      ST_WRITEBACK: begin
        ctl.rf_write   = 1'b1;
        ctl.mem_to_reg = (class_q == CLS_LOAD);
      end
      default: ;
    endcase
  end

  // Reset gates every output combinationally so requests drop in the reset cycle.
  assign ctl_out = rst ? '0 : ctl;

  assign bus.imemReq      = ctl_out.imem_req;
  assign bus.dmemRead     = ctl_out.dmem_read;
  assign bus.dmemWrite    = ctl_out.dmem_write;
  assign bus.PCWrite      = ctl_out.pc_write;
  assign bus.IRWrite      = ctl_out.ir_write;
  assign bus.regFileWrite = ctl_out.rf_write;
  assign bus.ALUOverride  = ctl_out.alu_override;
  assign bus.ALUSrcA      = ctl_out.alu_src_a;
  assign bus.ALUSrcB      = ALU_SRC_B_WIDTH'(ctl_out.alu_src_b);
  assign bus.pcSrc        = ctl_out.pc_src;
  assign bus.memToReg     = ctl_out.mem_to_reg;
  assign bus.trap         = !rst && (state_q == ST_TRAP);
  assign bus.trapCause    = rst ? 2'd0 : cause_q;
  assign bus.retired      = rst ? '0 : retired_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds an expected per-cycle trace for each
// instruction from its class, wait counts and branch outcome, then replays it.
module tb_multicycle_controller;

  localparam int MAXW = 15;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef struct packed {
    logic        imem_req;
    logic        dmem_read;
    logic        dmem_write;
    logic        pc_write;
    logic        ir_write;
    logic        rf_write;
    logic        alu_ovr;
    logic        src_a;
    logic [1:0]  src_b;
    logic        pc_src;
    logic        mem_to_reg;
    logic        trap;
    logic [1:0]  cause;
    logic [31:0] retired;
  } outs_t;

  typedef struct {
    logic       rst;
    logic       ir;
    logic       dr;
    logic       bt;
    logic [6:0] op;
    outs_t      exp;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_controller_if bus_if ();

  multicycle_controller #(.MAX_WAIT(MAXW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  outs_t got;
  assign got = {bus_if.imemReq, bus_if.dmemRead, bus_if.dmemWrite, bus_if.PCWrite,
                bus_if.IRWrite, bus_if.regFileWrite, bus_if.ALUOverride, bus_if.ALUSrcA,
                bus_if.ALUSrcB, bus_if.pcSrc, bus_if.memToReg, bus_if.trap,
                bus_if.trapCause, bus_if.retired};

  cyc_t       sched[$];
  int         vectors = 0;
  int         miscompares = 0;
  int         m_retired = 0;
  logic [1:0] m_cause = 2'd0;
  logic [6:0] cur_op = 7'd0;

  // 0 OP, 1 OP-IMM, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 LUI, 7 illegal
  function automatic int cls_of(input logic [6:0] op);
    case (op)
      OP_OP:     return 0;
      OP_OP_IMM: return 1;
      OP_LOAD:   return 2;
      OP_STORE:  return 3;
      OP_BRANCH: return 4;
      OP_JAL:    return 5;
      OP_LUI:    return 6;
      default:   return 7;
    endcase
  endfunction

  function automatic logic rb();
    return ($urandom & 1) != 0;
  endfunction

  function automatic outs_t base();
    outs_t o = '0;
    o.retired = 32'(m_retired);
    o.cause   = m_cause;
    return o;
  endfunction

  task automatic push(input logic ir, input logic dr, input logic bt, input outs_t e);
    cyc_t c;
    c.rst = 1'b0; c.ir = ir; c.dr = dr; c.bt = bt; c.op = cur_op; c.exp = e;
    sched.push_back(c);
  endtask

  task automatic add_reset(input int n);
    cyc_t c;
    for (int i = 0; i < n; i++) begin
      c.rst = 1'b1; c.ir = rb(); c.dr = rb(); c.bt = rb(); c.op = 7'($urandom);
      c.exp = '0;
      sched.push_back(c);
    end
    m_retired = 0;
    m_cause   = 2'd0;
  endtask

  task automatic add_trap(input int n);
    outs_t o;
    for (int i = 0; i < n; i++) begin
      o = base();
      o.trap = 1'b1;
      push(rb(), rb(), rb(), o);
    end
  endtask

  // fw/mw: stalled cycles before ready; MAXW or more means the handshake times out.
  task automatic add_instr(input logic [6:0] op, input int fw, input int mw, input logic bt);
    int    cls;
    outs_t o;
    cls    = cls_of(op);
    cur_op = op;
    for (int i = 0; i < fw && i < MAXW; i++) begin
      o = base(); o.imem_req = 1'b1; o.src_b = 2'd1; o.alu_ovr = 1'b1;
      push(1'b0, rb(), rb(), o);
    end
    if (fw >= MAXW) begin
      m_cause = 2'd2;
      return;
    end
    o = base(); o.imem_req = 1'b1; o.src_b = 2'd1; o.alu_ovr = 1'b1;
    o.pc_write = 1'b1; o.ir_write = 1'b1;
    push(1'b1, rb(), rb(), o);
    o = base();
    push(rb(), rb(), rb(), o);
    if (cls == 7) begin
      m_cause = 2'd1;
      return;
    end
    o = base();
    case (cls)
      0: begin o.src_a = 1'b1; o.src_b = 2'd0; end
      1, 6: o.src_b = 2'd2;
      2, 3: begin o.src_a = 1'b1; o.src_b = 2'd2; o.alu_ovr = 1'b1; end
      4: begin o.src_b = 2'd0; o.pc_src = bt; o.pc_write = bt; end
      5: begin o.pc_src = 1'b1; o.pc_write = 1'b1; end
      default: ;
    endcase
    push(rb(), rb(), (cls == 4) ? bt : rb(), o);
    if (cls == 4) begin
      m_retired++;
      return;
    end
    if (cls == 2 || cls == 3) begin
      o = base(); o.dmem_read = (cls == 2); o.dmem_write = (cls == 3);
      for (int i = 0; i < mw && i < MAXW; i++) push(rb(), 1'b0, rb(), o);
      if (mw >= MAXW) begin
        m_cause = 2'd2;
        return;
      end
      push(rb(), 1'b1, rb(), o);
      if (cls == 3) begin
        m_retired++;
        return;
      end
    end
    o = base(); o.rf_write = 1'b1; o.mem_to_reg = (cls == 2);
    push(rb(), rb(), rb(), o);
    m_retired++;
  endtask

  // Entered and left at posedge+1; outputs are sampled on the falling edge.
  task automatic run(input string tag);
    cyc_t c;
    while (sched.size() > 0) begin
      c = sched.pop_front();
      rst                = c.rst;
      bus_if.imemReady   = c.ir;
      bus_if.dmemReady   = c.dr;
      bus_if.branchTaken = c.bt;
      bus_if.opCode      = c.op;
      @(negedge clk);
      vectors++;
      if (got !== c.exp) begin
        miscompares++;
        $display("FAIL %s vec %0d: got %h expected %h", tag, vectors, got, c.exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    add_reset(3);
    run("reset");
  endtask

  task automatic test_op();
    add_instr(OP_OP, 0, 0, 1'b0);
    run("op");
  endtask

  task automatic test_load_wait();
    add_instr(OP_LOAD, 0, 3, 1'b0);
    run("load_wait");
  endtask

  task automatic test_branch();
    add_instr(OP_BRANCH, 0, 0, 1'b1);
    add_instr(OP_BRANCH, 0, 0, 1'b0);
    run("branch");
  endtask

  task automatic test_random();
    logic [6:0] ops [7] = '{OP_OP, OP_OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_LUI};
    int fw, mw;
    for (int k = 0; k < 40; k++) begin
      fw = (($urandom & 7) == 0) ? MAXW - 1 : int'($urandom_range(3));
      mw = (($urandom & 7) == 0) ? MAXW - 1 : int'($urandom_range(3));
      add_instr(ops[$urandom_range(6)], fw, mw, rb());
    end
    run("random");
  endtask

  task automatic test_wait_boundary();
    add_instr(OP_JAL, MAXW - 1, 0, 1'b0);
    add_instr(OP_STORE, 0, MAXW - 1, 1'b0);
    add_instr(OP_LOAD, MAXW - 1, MAXW - 1, 1'b0);
    run("wait_boundary");
  endtask

  task automatic test_fetch_timeout();
    add_instr(OP_OP, MAXW, 0, 1'b0);
    add_trap(4);
    add_reset(1);
    add_instr(OP_LUI, 0, 0, 1'b0);
    run("fetch_timeout");
  endtask

  task automatic test_illegal();
    logic [6:0] bad;
    add_instr(7'b1111111, 0, 0, 1'b0);
    add_trap(4);
    add_reset(2);
    do bad = 7'($urandom); while (cls_of(bad) != 7);
    add_instr(bad, 1, 0, 1'b0);
    add_trap(2);
    add_reset(1);
    add_instr(OP_OP_IMM, 0, 0, 1'b0);
    run("illegal");
  endtask

  task automatic test_mem_timeout();
    add_instr(OP_LOAD, 1, MAXW, 1'b0);
    add_trap(3);
    add_reset(1);
    add_instr(OP_STORE, 0, 0, 1'b0);
    run("mem_timeout");
  endtask

  task automatic test_reset_mid_store();
    add_instr(OP_OP, 0, 0, 1'b0);
    // Cut the timed-out store back to its fifth stalled MEMORY cycle, then reset.
    add_instr(OP_STORE, 0, MAXW, 1'b0);
    for (int i = 0; i < MAXW - 5; i++) void'(sched.pop_back());
    add_reset(1);
    add_instr(OP_OP, 0, 0, 1'b0);
    run("reset_mid_store");
  endtask

  initial begin
    rst                = 1'b1;
    bus_if.imemReady   = 1'b0;
    bus_if.dmemReady   = 1'b0;
    bus_if.branchTaken = 1'b0;
    bus_if.opCode      = 7'd0;
    @(posedge clk);
    #1;
    test_reset();
    test_op();
    test_load_wait();
    test_branch();
    test_random();
    test_wait_boundary();
    test_fetch_timeout();
    test_illegal();
    test_mem_timeout();
    test_reset_mid_store();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
